// File: rtl/vga_fb_arbiter_if.sv
// Host pixel-write channel into the frame-buffer arbiter.
// The host side drives the request; the arbiter answers with ready.
interface vga_fb_arbiter_if #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 8
);
  logic              iWR_VALID;
  logic [ADDR_W-1:0] iWR_ADDR;
  logic [DATA_W-1:0] iWR_DATA;
  logic              oWR_READY;

  modport master (
    output iWR_VALID,
    output iWR_ADDR,
    output iWR_DATA,
    input  oWR_READY
  );

  modport slave (
    input  iWR_VALID,
    input  iWR_ADDR,
    input  iWR_DATA,
    output oWR_READY
  );
endinterface

// File: rtl/vga_fb_arbiter.sv
// Single-port frame-buffer arbiter: VGA scan owns the RAM during active video,
// buffered host writes are committed one per cycle during blanking.
module vga_fb_arbiter #(
  parameter int ADDR_W     = 19,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          iVGA_CLK,
  input  logic                          iRST_n,
  input  logic                          iBLANK_n,
  input  logic                          iHS,
  input  logic                          iVS,
  vga_fb_arbiter_if.slave               wrBus,
  output logic [ADDR_W-1:0]             oMEM_ADDR,
  output logic [DATA_W-1:0]             oMEM_DATA,
  output logic                          oMEM_WE,
  output logic                          oFRAME_START,
  output logic [$clog2(FIFO_DEPTH):0]   oPENDING
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] scanAddr;
  logic [CNT_W-1:0]  count;
  logic [PTR_W-1:0]  wrPtr;
  logic [PTR_W-1:0]  rdPtr;
  logic              vsD;
  logic              wrReady;
  logic              doPush;
  logic              doPop;

  logic [ADDR_W-1:0] fifoAddr [FIFO_DEPTH];
  logic [DATA_W-1:0] fifoData [FIFO_DEPTH];

  // A full FIFO refuses a push even when it pops in the same cycle.
  assign wrReady         = (count < CNT_W'(FIFO_DEPTH)) && iRST_n;
  assign wrBus.oWR_READY = wrReady;
  assign doPush          = wrBus.iWR_VALID && wrReady;
  assign doPop           = !iBLANK_n && (count != '0);
  assign oPENDING        = count;

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      scanAddr <= '0;
    end else if (!iHS && !iVS) begin
      scanAddr <= '0;
    end else if (iBLANK_n) begin
      scanAddr <= scanAddr + ADDR_W'(1);
    end
  end

  always_ff @(posedge iVGA_CLK) begin
    if (doPush) begin
      fifoAddr[wrPtr] <= wrBus.iWR_ADDR;
      fifoData[wrPtr] <= wrBus.iWR_DATA;
    end
  end

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + PTR_W'(1);
      if (doPop)  rdPtr <= rdPtr + PTR_W'(1);
      case ({doPush, doPop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Frame start is registered so it lands one cycle after iVS is seen falling.
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      vsD          <= 1'b1;
      oFRAME_START <= 1'b0;
    end else begin
      vsD          <= iVS;
      oFRAME_START <= vsD && !iVS;
    end
  end

  always_comb begin
    oMEM_ADDR = scanAddr;
    oMEM_DATA = '0;
    oMEM_WE   = 1'b0;
    if (doPop) begin
      oMEM_ADDR = fifoAddr[rdPtr];
      oMEM_DATA = fifoData[rdPtr];
      oMEM_WE   = 1'b1;
    end
  end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Randomized and directed bench for vga_fb_arbiter against a queue-based model
// of the blanking-only commit rule, the scan counter and the frame-start pulse.
module tb_vga_fb_arbiter;

  localparam int ADDR_W = 19;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;

  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } entry_t;

  logic                     clock;
  logic                     rstN;
  logic                     blank;
  logic                     hs;
  logic                     vs;
  logic [ADDR_W-1:0]        memAddr;
  logic [DATA_W-1:0]        memData;
  logic                     memWe;
  logic                     frameStart;
  logic [$clog2(DEPTH):0]   pending;

  vga_fb_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) wrBus ();

  vga_fb_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(DEPTH)) dut (
    .iVGA_CLK     (clock),
    .iRST_n       (rstN),
    .iBLANK_n     (blank),
    .iHS          (hs),
    .iVS          (vs),
    .wrBus        (wrBus),
    .oMEM_ADDR    (memAddr),
    .oMEM_DATA    (memData),
    .oMEM_WE      (memWe),
    .oFRAME_START (frameStart),
    .oPENDING     (pending)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int vectors     = 0;
  int miscompares = 0;

  entry_t            hostQ[$];
  entry_t            modelQ[$];
  logic [ADDR_W-1:0] modelScan;
  logic              modelVsPrev;
  logic              modelFs;

  task automatic modelReset();
    modelQ.delete();
    modelScan   = '0;
    modelVsPrev = 1'b1;
    modelFs     = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    logic              expWe;
    logic [ADDR_W-1:0] expAddr;
    logic [DATA_W-1:0] expData;
    expWe   = 1'b0;
    expAddr = modelScan;
    expData = '0;
    if (!blank && modelQ.size() > 0) begin
      expWe   = 1'b1;
      expAddr = modelQ[0].a;
      expData = modelQ[0].d;
    end
    check("mem_we",      32'(memWe),               32'(expWe));
    check("mem_addr",    32'(memAddr),             32'(expAddr));
    check("mem_data",    32'(memData),             32'(expData));
    check("wr_ready",    32'(wrBus.oWR_READY),     32'(rstN && modelQ.size() < DEPTH));
    check("pending",     32'(pending),             32'(modelQ.size()));
    check("frame_start", 32'(frameStart),          32'(modelFs));
  endtask

  // One pixel clock: drive, check mid-cycle, then advance the model at the edge.
  task automatic applyStimulus();
    logic accept;
    wrBus.iWR_VALID = (hostQ.size() > 0);
    wrBus.iWR_ADDR  = (hostQ.size() > 0) ? hostQ[0].a : '0;
    wrBus.iWR_DATA  = (hostQ.size() > 0) ? hostQ[0].d : '0;
    @(negedge clock);
    checkOutput();
    @(posedge clock);
    if (!rstN) begin
      modelReset();
    end else begin
      accept = (hostQ.size() > 0) && (modelQ.size() < DEPTH);
      if (!blank && modelQ.size() > 0) void'(modelQ.pop_front());
      if (accept) modelQ.push_back(hostQ.pop_front());
      if (!hs && !vs)  modelScan = '0;
      else if (blank)  modelScan = modelScan + 1'b1;
      modelFs     = modelVsPrev && !vs;
      modelVsPrev = vs;
    end
    #1;
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus();
  endtask

  task automatic hostWrite(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    entry_t e;
    e.a = a;
    e.d = d;
    hostQ.push_back(e);
  endtask

  initial begin
    rstN            = 1'b0;
    blank           = 1'b1;
    hs              = 1'b1;
    vs              = 1'b1;
    wrBus.iWR_VALID = 1'b0;
    wrBus.iWR_ADDR  = '0;
    wrBus.iWR_DATA  = '0;
    modelReset();
    @(posedge clock);
    #1;
    runCycles(3);
    rstN = 1'b1;

    // Active video line: scan address walks 0..639, then a sync clear.
    runCycles(640);
    hs = 1'b0;
    vs = 1'b0;
    runCycles(1);
    hs = 1'b1;
    vs = 1'b1;
    runCycles(3);

    // Single write held off until blanking.
    hostWrite(19'h00010, 8'hAB);
    runCycles(6);
    blank = 1'b0;
    runCycles(3);
    blank = 1'b1;

    // Five back-to-back writes against a four-entry FIFO.
    for (int i = 0; i < 5; i++) hostWrite(ADDR_W'(32'h100 + i), DATA_W'(8'h30 + i));
    runCycles(8);
    blank = 1'b0;
    runCycles(7);
    blank = 1'b1;

    // Push and pop in the same blanking cycle with two queued.
    for (int i = 0; i < 2; i++) hostWrite(ADDR_W'(32'h200 + i), DATA_W'(8'h60 + i));
    runCycles(4);
    hostWrite(19'h00300, 8'h77);
    blank = 1'b0;
    runCycles(5);
    blank = 1'b1;

    // Frame-start pulse on iVS 1,1,0,0,1.
    vs = 1'b1; runCycles(2);
    vs = 1'b0; runCycles(2);
    vs = 1'b1; runCycles(3);

    // Reset mid-blanking with three entries pending.
    for (int i = 0; i < 4; i++) hostWrite(ADDR_W'(32'h400 + i), DATA_W'(8'h90 + i));
    runCycles(6);
    blank = 1'b0;
    runCycles(1);
    rstN = 1'b0;
    modelReset();
    hostQ.delete();
    runCycles(3);
    rstN = 1'b1;
    runCycles(4);
    blank = 1'b1;

    // Random traffic with sync pulses and blanking windows.
    for (int i = 0; i < 1500; i++) begin
      blank = ($urandom_range(0, 2) != 0);
      hs    = ($urandom_range(0, 40) != 0);
      vs    = ($urandom_range(0, 30) != 0);
      if ($urandom_range(0, 2) == 0 && hostQ.size() < 6)
        hostWrite(ADDR_W'($urandom), DATA_W'($urandom));
      applyStimulus();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
